// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder
// Purpose  : Behavioural DRAM-side responder for a row/column DRAM port.
//            Decodes ACTIVATE / COLUMN / PRECHARGE, stores 32-bit words in
//            four byte-lane arrays and returns reads after CAS_LAT edges.
// Options  : `define DRAM_TIMING_CHECK_EN to enable the tRCD check.
// Revision : 1.0 - initial release
// ============================================================================
module dram_responder #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 10,
  parameter int CAS_LAT  = 3,
  parameter int T_RCD    = 2,
  parameter int A_BITS   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSn,
  input  logic              RASn,
  input  logic              CASn,
  input  logic [3:0]        WEn,
  input  logic [A_BITS-1:0] A,
  input  logic [31:0]       D,
  output logic [31:0]       Q,
  output logic              err
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [ROW_BITS-1:0] row, row_nx;
  logic                err_nx;
  logic                cmd_act, cmd_col, cmd_pre;
  logic                col_ok;
  logic                wr_en, rd_en;
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]         rd_word;
  logic [31:0]         pipe_data [CAS_LAT];
  logic [CAS_LAT-1:0]  pipe_vld;
  logic                unused_bits;

  // Command decode; CSn high masks everything into a NOP
  assign cmd_act = !CSn && !RASn &&  CASn;
  assign cmd_col = !CSn &&  RASn && !CASn;
  assign cmd_pre = !CSn && !RASn && !CASn;

  // Word address is the open row concatenated with the column bits of A
  assign addr = {row, A[COL_BITS-1:0]};

`ifdef DRAM_TIMING_CHECK_EN
  localparam int RCD_W = (T_RCD > 2) ? $clog2(T_RCD) : 1;
  localparam logic [RCD_W-1:0] RCD_INIT = RCD_W'((T_RCD > 0) ? T_RCD - 1 : 0);

  logic [RCD_W-1:0] rcd_cnt;

  // Column commands are only legal once the activate-to-column delay expired
  assign col_ok = (rcd_cnt == '0);

  // tRCD counter: loaded on activate, counts down to zero while a row is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_cnt <= '0;
    end else if (state == IDLE && cmd_act) begin
      rcd_cnt <= RCD_INIT;
    end else if (state == OPEN && rcd_cnt != '0) begin
      rcd_cnt <= rcd_cnt - RCD_W'(1);
    end
  end

  assign unused_bits = &{1'b0, A};
`else
  // Without timing checks a column may follow activate on the very next edge
  assign col_ok = 1'b1;

  assign unused_bits = &{1'b0, A, T_RCD};
`endif

  // Next-state, row latch, sticky error and array access strobes
  always_comb begin
    state_nx = state;
    row_nx   = row;
    err_nx   = err;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_act) begin
          state_nx = OPEN;
          row_nx   = A[ROW_BITS-1:0];
        end else if (cmd_col) begin
          err_nx = 1'b1;
        end
      end
      OPEN: begin
        if (cmd_pre) begin
          state_nx = IDLE;
        end else if (cmd_act) begin
          // Re-activate without precharge: flag it, keep the old row open
          err_nx = 1'b1;
        end else if (cmd_col) begin
          if (!col_ok) begin
            err_nx = 1'b1;
          end else if (WEn == 4'hF) begin
            rd_en = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state register: FSM state, open row and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      err   <= err_nx;
    end
  end

  // Byte-lane storage; contents deliberately survive reset so preloads persist
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Lane k is written only when its active-low enable is asserted
    always_ff @(posedge clk) begin
      if (wr_en && !WEn[k]) begin
        mem[addr] <= D[8*k +: 8];
      end
    end

    assign rd_word[8*k +: 8] = mem[addr];
  end

  // CAS-latency pipeline: array word captured at the command edge, Q loads
  // exactly CAS_LAT edges later and otherwise holds its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      Q        <= '0;
      for (int i = 0; i < CAS_LAT; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_data[0] <= rd_word;
      for (int i = 1; i < CAS_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      if (pipe_vld[CAS_LAT-1]) begin
        Q <= pipe_data[CAS_LAT-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Clocked DRAM-side responder for the accelerator's row/column DRAM port (CSn, RASn, CASn, WEn, A, D, Q).
- Decodes activate, column read/write and precharge commands from the accelerator top.
- Stores 32-bit words in four byte-lane arrays and returns read data after a fixed CAS latency.
- Stands in for the external DRAM in block and system simulation; arrays are preloadable with $readmemh.

Parameters:
ROW_BITS, 13, row address width (taken from A[ROW_BITS-1:0] on activate)
COL_BITS, 10, column address width (taken from A[COL_BITS-1:0] on column access); word address = {row, col}
CAS_LAT, 3, cycles from column-read command edge to Q update (legal 1..8)
T_RCD, 2, minimum cycles from activate to first column command (used only with timing checks)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
CSn  input  1  chip select, active low; high = NOP
RASn  input  1  row address strobe, active low
CASn  input  1  column address strobe, active low
WEn  input  4  per-byte write enable, active low; 4'hF on a column command = read
A  input  13  multiplexed row/column address
D  input  32  write data, byte lane k = D[8k+7:8k]
Q  output  32  read data
err  output  1  sticky protocol-error flag

Behaviour:
- Interface decided as stated: one clock clk; reset rst is asynchronous and active-high.
- Commands are sampled on the rising clk edge when CSn=0:
  - RASn=0, CASn=1: ACTIVATE.
  - RASn=1, CASn=0: COLUMN.
  - RASn=0, CASn=0: PRECHARGE.
  - RASn=1, CASn=1: NOP.
- CSn=1 is NOP regardless of the other inputs.
- State machine:
  - IDLE: no row open.
    - ACTIVATE latches row=A[ROW_BITS-1:0] and goes to OPEN; rcd_cnt loads T_RCD-1.
    - COLUMN in IDLE sets err and is ignored.
    - PRECHARGE in IDLE is a legal NOP.
  - OPEN: row open.
    - COLUMN accesses word {row, A[COL_BITS-1:0]}.
    - PRECHARGE returns to IDLE.
    - ACTIVATE in OPEN sets err and is ignored; the row stays open with the old row.
- rcd_cnt decrements to 0 while OPEN.
- Write (COLUMN, WEn!=4'hF):
  - Each byte lane k with WEn[k]=0 takes D lane k at that edge; other lanes are unchanged.
  - No effect on Q.
- Read (COLUMN, WEn=4'hF):
  - The array word is sampled at the command edge and pushed into a CAS_LAT-deep data/valid pipeline.
  - Q takes the data exactly CAS_LAT edges after the command.
  - Q holds its last value otherwise; it never returns to 0 except on reset.
  - Back-to-back reads on consecutive cycles return on consecutive cycles, fully pipelined.
- Write at edge N followed by a read of the same word at edge N+1 returns the new data.
- Array read and write are never simultaneous, since there is one command per cycle.
- Reset (any time, including mid-burst):
  - Q=0, err=0, state=IDLE, rcd_cnt=0, read pipeline valids cleared.
  - In-flight reads are dropped.
  - Array contents are NOT cleared, so preloads survive reset.
- err is sticky until reset. err sets on the edge of the offending command and is visible the next cycle.
- Address bits of A above ROW_BITS or COL_BITS are ignored.

Optional Feature:
- DRAM_TIMING_CHECK_EN defined:
  - A COLUMN command while OPEN with rcd_cnt!=0 is a tRCD violation: err sets and the command is ignored (no write, no read push).
  - A PRECHARGE with a read still in flight is legal.
- DRAM_TIMING_CHECK_EN undefined:
  - The rcd_cnt logic is removed.
  - COLUMN is accepted on the cycle immediately after ACTIVATE.
  - err is driven only by the IDLE and OPEN protocol errors above.

Test Plan:
1. ACTIVATE row 0x0006, wait T_RCD, write col 0x000 WEn=0, D=0xDEADBEEF, then read the same column -> Q=0xDEADBEEF exactly CAS_LAT edges after the read edge; err=0.
2. Partial write over 0x11223344 with WEn=4'b1010, D=0xAABBCCDD -> read returns 0x11BB33DD.
3. Four back-to-back reads of cols 0..3 preloaded with 1,2,3,4 -> Q shows 1,2,3,4 on four consecutive cycles starting CAS_LAT after the first read.
4. COLUMN in IDLE, and a second ACTIVATE while OPEN -> err=1 next cycle; memory unchanged; the original row still accessible.
5. With DRAM_TIMING_CHECK_EN and T_RCD=2: COLUMN write one cycle after ACTIVATE -> err=1 and the word is unchanged. Same sequence without the macro -> write lands, err=0.
6. Issue a read, assert rst before CAS_LAT elapses, release -> Q stays 0, err=0, state IDLE, preloaded array word still readable after ACTIVATE.
